// File: rtl/count_pkg.sv
// Shared constants for the count display driver: active-low seven-segment
// patterns ({g,f,e,d,c,b,a}), active-low digit enables and the scan phase type.
package count_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low digit enables: bit0 drives the ones digit, bit1 the tens digit
  localparam logic [1:0] DIG_ONES  = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;
  localparam logic [1:0] DIG_NONE  = 2'b11;

  localparam logic [3:0] DIGIT_MIN = 4'd0;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic {
    PHASE_ONES = 1'b0,
    PHASE_TENS = 1'b1
  } phase_t;

endpackage

// File: rtl/count_display_driver_seg7_decode.sv
// seg7_decode: combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not digits and produce an all-off pattern.
module seg7_decode
  import count_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Map one BCD code to its segment pattern
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: extends an upstream decade counter with a tens digit
// (tracked from carry/borrow transitions of the ones digit) and multiplexes
// both digits onto one seven-segment display.
// Optional build macro COUNT_DISPLAY_BLANK_EN: blanks the tens digit while it is 0.
module count_display_driver
  import count_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [3:0] number,
  input  logic       zero,
  output logic [3:0] tens,
  output logic       tens_wrap,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_sel
);

  localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

  logic [3:0] prev_num_r;
  logic [7:0] scan_cnt_r;
  phase_t     phase_r;

  logic       carry_s;
  logic       borrow_s;
  logic [3:0] dec_in_s;
  logic [6:0] dec_out_s;
  logic [6:0] seg_next_s;

  // Detect the ones digit rolling over in the current counting direction
  always_comb begin
    carry_s  = mode && (prev_num_r == DIGIT_MAX) && (number == DIGIT_MIN);
    borrow_s = !mode && (prev_num_r == DIGIT_MIN) && (number == DIGIT_MAX);
  end

  // Select which digit value feeds the shared decoder
  always_comb begin
    if (phase_r == PHASE_TENS) begin
      dec_in_s = tens;
    end else begin
      dec_in_s = number;
    end
  end

  seg7_decode u_decode (
    .digit (dec_in_s),
    .seg   (dec_out_s)
  );

  // Apply optional leading-zero blanking on the tens digit
  always_comb begin
    seg_next_s = dec_out_s;
`ifdef COUNT_DISPLAY_BLANK_EN
    if ((phase_r == PHASE_TENS) && (tens == DIGIT_MIN)) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = dec_out_s;
    end
`else
    if (phase_r == PHASE_TENS) begin
      seg_next_s = dec_out_s;
    end else begin
      seg_next_s = dec_out_s;
    end
`endif
  end

  // Track the previous ones digit and the tens digit with its wrap pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_num_r <= 4'd0;
      tens       <= 4'd0;
      tens_wrap  <= 1'b0;
    end else begin
      prev_num_r <= number;
      if (carry_s) begin
        tens      <= (tens == DIGIT_MAX) ? DIGIT_MIN : tens + 4'd1;
        tens_wrap <= (tens == DIGIT_MAX);
      end else if (borrow_s) begin
        tens      <= (tens == DIGIT_MIN) ? DIGIT_MAX : tens - 4'd1;
        tens_wrap <= (tens == DIGIT_MIN);
      end else begin
        tens_wrap <= 1'b0;
      end
    end
  end

  // Scan timer: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_r <= 8'd0;
      phase_r    <= PHASE_ONES;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= 8'd0;
      phase_r    <= (phase_r == PHASE_ONES) ? PHASE_TENS : PHASE_ONES;
    end else begin
      scan_cnt_r <= scan_cnt_r + 8'd1;
    end
  end

  // Register display outputs for the digit selected this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      dig_sel <= DIG_NONE;
    end else begin
      seg <= seg_next_s;
      case (phase_r)
        PHASE_ONES: begin
          dig_sel <= DIG_ONES;
          dp      <= !zero;
        end
        PHASE_TENS: begin
          dig_sel <= DIG_TENS;
          dp      <= 1'b1;
        end
        default: begin
          dig_sel <= DIG_NONE;
          dp      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed scenarios followed by
// random traffic, all checked every cycle against an arithmetic reference model.
module tb_count_display_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b1;
  logic [3:0] number = 4'd0;
  logic       zero = 1'b0;
  logic [3:0] tens;
  logic       tens_wrap;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] dig_sel;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_tens = 0;
  int         m_prev = 0;
  int         m_n    = 0;
  logic       e_wrap = 1'b0;
  logic [6:0] e_seg  = 7'b1111111;
  logic       e_dp   = 1'b1;
  logic [1:0] e_dig  = 2'b11;
  logic [6:0] dec_tab [16];

  count_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .number(number), .zero(zero),
    .tens(tens), .tens_wrap(tens_wrap), .seg(seg), .dp(dp), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // one clock: advance the model with the inputs sampled at this edge, then check
  task automatic cyc();
    int ph;
    int shown;
    @(posedge clk);
    if (!rst_n) begin
      m_tens = 0; m_prev = 0; m_n = 0;
      e_wrap = 1'b0; e_seg = 7'b1111111; e_dp = 1'b1; e_dig = 2'b11;
    end else begin
      ph     = (m_n / SD) % 2;
      e_dig  = (ph == 1) ? 2'b01 : 2'b10;
      shown  = (ph == 1) ? m_tens : int'(number);
      e_seg  = dec_tab[shown];
`ifdef COUNT_DISPLAY_BLANK_EN
      if (ph == 1 && m_tens == 0) e_seg = 7'b1111111;
`endif
      e_dp   = !(ph == 0 && zero);
      e_wrap = 1'b0;
      if (mode && m_prev == 9 && number == 4'd0) begin
        e_wrap = (m_tens == 9);
        m_tens = (m_tens + 1) % 10;
      end else if (!mode && m_prev == 0 && number == 4'd9) begin
        e_wrap = (m_tens == 0);
        m_tens = (m_tens + 9) % 10;
      end
      m_prev = int'(number);
      m_n++;
    end
    #1;
    chk("tens",      7'(tens),      7'(m_tens));
    chk("tens_wrap", 7'(tens_wrap), 7'(e_wrap));
    chk("seg",       seg,           e_seg);
    chk("dp",        7'(dp),        7'(e_dp));
    chk("dig_sel",   7'(dig_sel),   7'(e_dig));
  endtask

  task automatic step(input logic m, input logic [3:0] num, input logic z);
    mode = m; number = num; zero = z;
    cyc();
  endtask

  initial begin
    dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001; dec_tab[2] = 7'b0100100;
    dec_tab[3] = 7'b0110000; dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
    dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000; dec_tab[8] = 7'b0000000;
    dec_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b1111111;

    // reset state
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dig", 7'(dig_sel), 7'(2'b11));
    rst_n = 1'b1;

    // up carry: 7,8,9,0 -> tens 1, no wrap
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    step(1'b1, 4'd0, 1'b1);
    chk("carry_tens", 7'(tens), 7'd1);
    chk("carry_nowrap", 7'(tens_wrap), 7'd0);

    // back to tens 0, then down borrow 1,0,9 -> tens 9 with one-cycle wrap
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    step(1'b0, 4'd1, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd9, 1'b0);
    chk("borrow_tens", 7'(tens), 7'd9);
    chk("borrow_wrap", 7'(tens_wrap), 7'd1);
    step(1'b0, 4'd8, 1'b0);
    chk("borrow_wrap_end", 7'(tens_wrap), 7'd0);

    // scan with tens=3, number=5 (blanking/zero-tens cases also pass through here)
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 4'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd9, 1'b0);
      step(1'b1, 4'd0, 1'b0);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 4'd5, 1'b0);
    chk("scan_tens", 7'(tens), 7'd3);

    // illegal ones digit
    for (int i = 0; i < 8; i++) step(1'b1, 4'd12, 1'b0);
    chk("illegal_tens", 7'(tens), 7'd3);

    // mid-operation reset while a carry is pending with tens=7
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 4'd9, 1'b0);
      step(1'b1, 4'd0, 1'b0);
    end
    step(1'b1, 4'd9, 1'b0);
    chk("pre_reset_tens", 7'(tens), 7'd7);
    rst_n = 1'b0;
    step(1'b1, 4'd0, 1'b1);
    chk("midrst_tens", 7'(tens), 7'd0);
    chk("midrst_seg", seg, 7'b1111111);
    chk("midrst_dp", 7'(dp), 7'd1);
    chk("midrst_dig", 7'(dig_sel), 7'(2'b11));
    rst_n = 1'b1;

    // random traffic biased toward carry/borrow transitions
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] v;
      r = int'($urandom_range(0, 9));
      if (r < 4)      v = 4'd9;
      else if (r < 8) v = 4'd0;
      else            v = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 59) != 0);
      step(($urandom_range(0, 7) != 0) ? mode : ~mode, v, 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: cycles each digit stays selected; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all logic.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port mode  input  1  count direction of the upstream decade counter (1 = up, 0 = down).
REQ-005 SHALL have port number  input  4  upstream ones digit, sampled every cycle.
REQ-006 SHALL have port zero  input  1  upstream zero flag, sampled every cycle.
REQ-007 SHALL have port tens  output  4  registered tens digit, 0..9.
REQ-008 SHALL have port tens_wrap  output  1  one-cycle pulse when tens wraps (9->0 up, 0->9 down).
REQ-009 SHALL have port seg  output  7  registered active-low segments {g,f,e,d,c,b,a} for the selected digit.
REQ-010 SHALL have port dp  output  1  registered active-low decimal point.
REQ-011 SHALL have port dig_sel  output  2  registered active-low digit enables: bit0 = ones, bit1 = tens.

Function
REQ-012 SHALL hold prev_num, a copy of number delayed one cycle.
REQ-013 SHALL detect a carry when mode=1, prev_num=9 and number=0.
REQ-014 SHALL detect a borrow when mode=0, prev_num=0 and number=9.
REQ-015 SHALL update tens one cycle after a carry (+1, 9 wraps to 0) or a borrow (-1, 0 wraps to 9).
REQ-016 SHALL hold tens unchanged on every other number transition, including illegal values 10..15.
REQ-017 SHALL assert tens_wrap in the same cycle that tens updates with a wrap, and only then.
REQ-018 SHALL use a scan counter that counts 0..SCAN_DIV-1 and wraps; the digit-phase bit toggles on each wrap.
REQ-019 SHALL drive the ones digit in phase 0 (dig_sel=2'b10, seg=decode(number)) and the tens digit in phase 1 (dig_sel=2'b01, seg=decode(tens)).
REQ-020 SHALL use decode values 0..9 = standard segments; 10..15 = 7'b1111111 (all segments off).
REQ-021 SHALL drive dp low (lit) only in phase 0 while zero=1; dp is high otherwise.
REQ-022 SHALL register seg, dp and dig_sel, so they reflect the phase and inputs of the previous cycle (one-cycle latency).
REQ-023 SHALL never assert both dig_sel bits low in the same cycle.
REQ-024 SHALL, when a carry/borrow coincides with a phase switch, show the updated tens value on the first tens-phase cycle that follows the update.

Reset
REQ-025 SHALL, with rst_n=0 at a clk edge, set tens=0, tens_wrap=0, prev_num=0, scan counter=0, phase=0, seg=7'b1111111, dp=1 and dig_sel=2'b11.
REQ-026 SHALL give reset priority over all other updates, including a carry/borrow detected in the same cycle.
REQ-027 SHALL start the first cycle after reset release in phase 0 with scan count 0.

Configuration
REQ-028 SHALL, with macro COUNT_DISPLAY_BLANK_EN defined, blank the tens digit while tens=0 (seg=7'b1111111 in phase 1, dig_sel timing unchanged).
REQ-029 SHALL, without COUNT_DISPLAY_BLANK_EN, display tens=0 as the digit "0".

Structure
REQ-030 SHALL place the segment-pattern constants for 0..9, SEG_BLANK and the active-low digit-select encodings in shared package count_pkg.
REQ-031 SHALL implement decoding in sub-module seg7_decode (4-bit in, 7-bit active-low out, combinational), instantiated once and fed by a phase-selected mux.

Verification
REQ-032 SHALL cover up carry: mode=1, number 7,8,9,0 on successive cycles -> tens 0->1 one cycle after 0 is seen; tens_wrap stays 0.
REQ-033 SHALL cover down borrow: tens=0, mode=0, number 1,0,9 -> tens=9 one cycle after 9 is seen; tens_wrap pulses for exactly 1 cycle.
REQ-034 SHALL cover scan: SCAN_DIV=4, number=5, tens=3 -> dig_sel repeats 10,10,10,10,01,01,01,01; seg=7'b0010010 then 7'b0110000.
REQ-035 SHALL cover illegal input: number=12 -> seg=7'b1111111 in phase 0; tens unchanged.
REQ-036 SHALL cover mid-operation reset: rst_n=0 for 1 cycle while tens=7 and a carry is pending -> all outputs at REQ-025 values, tens=0.
REQ-037 SHALL cover blanking: with COUNT_DISPLAY_BLANK_EN and tens=0, phase 1 -> seg=7'b1111111; without the macro -> seg=7'b1000000.
